// File: rtl/matrix_col_reader_pkg.sv
// Shared types and constants for the matrix column reader.
// Used by the bank, the bus interface and the top.
package matrix_pkg;

    localparam int DIM    = 5;
    localparam int ELEM_W = 8;
    localparam int ROW_W  = DIM * ELEM_W;

    typedef logic signed [ELEM_W-1:0] elem_t;
    typedef logic [ROW_W-1:0]         row_t;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/matrix_col_reader_if.sv
// Row-in / column-out handshake bus of the matrix column reader.
// master = producer/consumer side, slave = reader side.
interface matrix_col_reader_if #(
    parameter int W = matrix_pkg::ROW_W
);
    import matrix_pkg::*;

    logic [W-1:0]        row_in;
    logic                row_valid;
    logic                row_ready;
    logic signed [W-1:0] col_out;
    logic                col_valid;
    logic                col_ready;
    logic                done;

    modport master (
        output row_in, row_valid, col_ready,
        input  row_ready, col_out, col_valid, done
    );

    modport slave (
        input  row_in, row_valid, col_ready,
        output row_ready, col_out, col_valid, done
    );

endinterface

// File: rtl/matrix_trans_bank.sv
// DIM x ROW_W register file: row write port, combinational
// column read (element i of the column = row i, element cidx).
module matrix_trans_bank #(
    parameter  int DIM    = 5,
    parameter  int ELEM_W = 8,
    localparam int ROW_W  = DIM * ELEM_W,
    localparam int CW     = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [CW-1:0]    waddr_i,
    input  logic [ROW_W-1:0] wdata_i,
    input  logic [CW-1:0]    cidx_i,
    output logic [ROW_W-1:0] col_o
);
    import matrix_pkg::*;

    logic [ROW_W-1:0] mem_q [DIM];

    // Row storage, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Gather element cidx of every row into one column word
    always_comb begin
        col_o = '0;
        for (int i = 0; i < DIM; i++) begin
            col_o[ROW_W-1-ELEM_W*i -: ELEM_W] =
                mem_q[i][ROW_W-1-ELEM_W*int'(cidx_i) -: ELEM_W];
        end
    end

endmodule

// File: rtl/matrix_col_reader.sv
// Loads DIM rows, then emits the DIM columns of the transpose.
// `define MATRIX_PINGPONG_EN for two banks (load while draining).
module matrix_col_reader #(
    parameter int DIM    = 5,
    parameter int ELEM_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    matrix_col_reader_if.slave bus
);
    import matrix_pkg::*;

    localparam int            RW   = DIM * ELEM_W;
    localparam int            CW   = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIM - 1);

    logic          row_ready;
    logic          col_valid;
    logic          row_fire;
    logic          col_fire;
    logic [CW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic          done_q, done_d;
    logic [RW-1:0] col_rd;

    assign row_fire = bus.row_valid && row_ready;
    assign col_fire = col_valid && bus.col_ready;

`ifndef MATRIX_PINGPONG_EN

    state_t state_q, state_d;

    matrix_trans_bank #(
        .DIM    (DIM),
        .ELEM_W (ELEM_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (row_fire),
        .waddr_i (r_q),
        .wdata_i (bus.row_in),
        .cidx_i  (c_q),
        .col_o   (col_rd)
    );

    // State, counters and done pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            r_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    // Next state: fill rows, then hand out columns
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        done_d  = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (row_fire) begin
                    r_d = (r_q == LAST) ? '0 : r_q + 1'b1;
                    if (r_q == LAST) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (col_fire) begin
                    c_d = (c_q == LAST) ? '0 : c_q + 1'b1;
                    if (c_q == LAST) begin
                        state_d = LOAD;
                        done_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        row_ready = !rst && (state_q == LOAD);
        col_valid = (state_q == DRAIN);
    end

`else

    logic [1:0]    full_q, full_d;
    logic          wsel_q, wsel_d;
    logic          rsel_q, rsel_d;
    state_t        rd_state;
    logic [RW-1:0] col_b0, col_b1;

    matrix_trans_bank #(
        .DIM    (DIM),
        .ELEM_W (ELEM_W)
    ) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (row_fire && !wsel_q),
        .waddr_i (r_q),
        .wdata_i (bus.row_in),
        .cidx_i  (c_q),
        .col_o   (col_b0)
    );

    matrix_trans_bank #(
        .DIM    (DIM),
        .ELEM_W (ELEM_W)
    ) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we_i    (row_fire && wsel_q),
        .waddr_i (r_q),
        .wdata_i (bus.row_in),
        .cidx_i  (c_q),
        .col_o   (col_b1)
    );

    assign col_rd = rsel_q ? col_b1 : col_b0;

    // Bank flags, bank selects, counters and done pulse register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= '0;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            r_q    <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
        end else begin
            full_q <= full_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            r_q    <= r_d;
            c_q    <= c_d;
            done_q <= done_d;
        end
    end

    // Next state: a filled write bank flips the write select; a
    // drained read bank flips the read select onto the other bank
    always_comb begin
        full_d = full_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        r_d    = r_q;
        c_d    = c_q;
        done_d = 1'b0;
        if (row_fire) begin
            r_d = (r_q == LAST) ? '0 : r_q + 1'b1;
            if (r_q == LAST) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
            end
        end
        if (col_fire) begin
            c_d = (c_q == LAST) ? '0 : c_q + 1'b1;
            if (c_q == LAST) begin
                full_d[rsel_q] = 1'b0;
                rsel_d         = ~rsel_q;
                done_d         = 1'b1;
            end
        end
    end

    // Handshake outputs decoded from bank flags
    always_comb begin
        rd_state  = full_q[rsel_q] ? DRAIN : LOAD;
        row_ready = !rst && !full_q[wsel_q];
        col_valid = (rd_state == DRAIN);
    end

`endif

    assign bus.row_ready = row_ready;
    assign bus.col_valid = col_valid;
    assign bus.col_out   = col_valid ? col_rd : '0;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_matrix_col_reader.sv
// Scoreboard bench for matrix_col_reader.
// Build with +define+MATRIX_PINGPONG_EN to add the streaming case.
module tb_matrix_col_reader;
    import matrix_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    matrix_col_reader_if bus ();

    matrix_col_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [39:0] exp_q [$];
    logic [39:0] e;
    int checks     = 0;
    int failures   = 0;
    int done_seen  = 0;
    int done_exp   = 0;
    int cols_taken = 0;

    task automatic chk(input string nm, input logic [39:0] act,
                       input logic [39:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s act=timeout req=event", nm);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer
    task automatic send_row(input logic [39:0] d);
        bit ok;
        ok            = 0;
        bus.row_in    = d;
        bus.row_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.row_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("row_accept");
        sync();
        bus.row_valid = 1'b0;
        bus.row_in    = 40'hDEAD_BEEF_55;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) timeout("drain");
        repeat (2) @(posedge clk);
        sync();
    endtask

    task automatic push5(input logic [39:0] a, b, c, d, f);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
        exp_q.push_back(f);
    endtask

    task automatic send_mat_a();
        send_row(40'h01_02_03_04_05);
        send_row(40'h06_07_08_09_10);
        send_row(40'h11_12_13_14_15);
        send_row(40'h16_17_18_19_20);
        send_row(40'h21_22_23_24_25);
    endtask

    task automatic push_mat_a();
        push5(40'h01_06_11_16_21, 40'h02_07_12_17_22,
              40'h03_08_13_18_23, 40'h04_09_14_19_24,
              40'h05_10_15_20_25);
    endtask

    task automatic send_mat_b();
        send_row(40'h11_11_11_11_11);
        send_row(40'h22_22_22_22_22);
        send_row(40'h33_33_33_33_33);
        send_row(40'h44_44_44_44_44);
        send_row(40'h55_55_55_55_55);
    endtask

    task automatic push_mat_b();
        for (int i = 0; i < 5; i++) exp_q.push_back(40'h11_22_33_44_55);
    endtask

    // Monitor: pops the scoreboard on every column transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) done_seen++;
            if (bus.col_valid && bus.col_ready) begin
                cols_taken++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL col_extra act=%h req=none", bus.col_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("col", bus.col_out, e);
                end
            end
        end
    end

    initial begin
        bus.row_in    = '0;
        bus.row_valid = 1'b0;
        bus.col_ready = 1'b0;
        rst           = 1'b1;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_row_ready", bus.row_ready, 0);
        chk("rst_col_valid", bus.col_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_col_out", bus.col_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", bus.row_ready, 1);
        sync();

        // basic transpose, col_ready high throughout
        bus.col_ready = 1'b1;
        push_mat_a();
        done_exp++;
        send_mat_a();
        @(negedge clk);
        chk("latency_col_valid", bus.col_valid, 1);
        wait_drain();

        // negative elements copied bit-exact
        push5(40'hFF_00_00_00_00, 40'h80_00_00_00_00,
              40'h01_00_00_00_00, 40'h7F_00_00_00_00,
              40'h00_00_00_00_00);
        done_exp++;
        send_row(40'hFF_80_01_7F_00);
        for (int i = 0; i < 4; i++) send_row(40'h0);
        wait_drain();

        // back-pressure at column 2
        bus.col_ready = 1'b0;
        push_mat_a();
        done_exp++;
        send_mat_a();
        @(negedge clk);
        chk("hold_pre_valid", bus.col_valid, 1);
        sync();
        bus.col_ready = 1'b1;
        repeat (2) sync();
        bus.col_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_col_out", bus.col_out, 40'h03_08_13_18_23);
            chk("hold_col_valid", bus.col_valid, 1);
`ifndef MATRIX_PINGPONG_EN
            chk("hold_row_ready", bus.row_ready, 0);
`endif
        end
        sync();
        bus.col_ready = 1'b1;
        wait_drain();

        // reset after three rows discards the partial matrix
        send_row(40'hAA_AA_AA_AA_AA);
        send_row(40'hBB_BB_BB_BB_BB);
        send_row(40'hCC_CC_CC_CC_CC);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_row_ready", bus.row_ready, 0);
        chk("mid_rst_col_valid", bus.col_valid, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_col_out", bus.col_out, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_back", bus.row_ready, 1);
        sync();
        push_mat_b();
        done_exp++;
        send_mat_b();
        wait_drain();

`ifdef MATRIX_PINGPONG_EN
        // two matrices streamed back to back
        begin
            int base;
            base = cols_taken;
            push_mat_a();
            push_mat_b();
            done_exp += 2;
            fork
                begin
                    send_mat_a();
                    send_mat_b();
                end
                begin
                    for (int i = 0; i < 300; i++) begin
                        @(negedge clk);
                        #1;
                        if (cols_taken == base + 5) break;
                    end
                    if (cols_taken != base + 5) timeout("pp_first_matrix");
                    @(negedge clk);
                    chk("pp_no_gap", bus.col_valid, 1);
                end
            join
            wait_drain();
        end
`endif

        repeat (3) sync();
        chk("done_count", 40'(done_seen), 40'(done_exp));
        chk("queue_empty", 40'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
